// File: rtl/alu_pkg.sv
// Shared definitions for the two-requester ALU arbiter: data width, operation
// encodings and FSM state type.
package alu_pkg;

  localparam int unsigned DataWidth = 8;

  typedef logic [1:0] modo_t;

  localparam modo_t MODO_ADD = 2'b00;
  localparam modo_t MODO_SUB = 2'b01;
  localparam modo_t MODO_MUL = 2'b10;
  localparam modo_t MODO_SHL = 2'b11;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StIssue = 2'b01,
    StWait  = 2'b10,
    StDone  = 2'b11
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: on a tie the requester not served last wins;
// a lone request wins regardless of the pointer.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic gnt0,
  output logic gnt1
);

  // last = 1 means requester 1 was served most recently.
  assign gnt0 = req0 & (~req1 | last);
  assign gnt1 = req1 & (~req0 | ~last);

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one shared fixed-latency ALU; one operation in
// flight at a time, result routed back to the owner with a one-cycle done pulse.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0,
  input  logic                 req1,
  input  logic [DataWidth-1:0] a0,
  input  logic [DataWidth-1:0] a1,
  input  logic [DataWidth-1:0] b0,
  input  logic [DataWidth-1:0] b1,
  input  modo_t                modo0,
  input  modo_t                modo1,
  output logic                 done0,
  output logic                 done1,
  output logic [DataWidth-1:0] res0,
  output logic [DataWidth-1:0] res1,
  output logic                 busy,
  output logic                 alu_en,
  output logic [DataWidth-1:0] alu_a,
  output logic [DataWidth-1:0] alu_b,
  output modo_t                alu_modo,
  input  logic [DataWidth-1:0] alu_c
);

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 owner_q, owner_d;
  logic                 last_q, last_d;
  logic [DataWidth-1:0] res0_q, res0_d, res1_q, res1_d;
  logic [DataWidth-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  modo_t                alu_modo_q, alu_modo_d;
  logic                 done0_q, done0_d, done1_q, done1_d;
  logic                 busy_q, busy_d, alu_en_q, alu_en_d;
  logic                 gnt0, gnt1;

  rr_arb2 u_rr_arb2 (
    .req0 (req0),
    .req1 (req1),
    .last (last_q),
    .gnt0 (gnt0),
    .gnt1 (gnt1)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    last_d     = last_q;
    res0_d     = res0_q;
    res1_d     = res1_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_modo_d = alu_modo_q;

    case (state_q)
      StIdle: begin
        if (gnt0 || gnt1) begin
          owner_d    = gnt1;
          alu_a_d    = gnt1 ? a1 : a0;
          alu_b_d    = gnt1 ? b1 : b0;
          alu_modo_d = gnt1 ? modo1 : modo0;
          state_d    = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = 4'(LAT);
        state_d = StWait;
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          if (owner_q) res1_d = alu_c;
          else         res0_d = alu_c;
          state_d = StDone;
        end
      end
      StDone: begin
        last_d  = owner_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered from the next state so they line up with it.
    busy_d   = (state_d != StIdle);
    alu_en_d = (state_d == StIssue);
    done0_d  = (state_d == StDone) && !owner_d;
    done1_d  = (state_d == StDone) && owner_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      res0_q     <= '0;
      res1_q     <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_modo_q <= MODO_ADD;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      busy_q     <= 1'b0;
      alu_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      res0_q     <= res0_d;
      res1_q     <= res1_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_modo_q <= alu_modo_d;
      done0_q    <= done0_d;
      done1_q    <= done1_d;
      busy_q     <= busy_d;
      alu_en_q   <= alu_en_d;
    end
  end

  assign done0    = done0_q;
  assign done1    = done1_q;
  assign res0     = res0_q;
  assign res1     = res1_q;
  assign busy     = busy_q;
  assign alu_en   = alu_en_q;
  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_modo = alu_modo_q;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter LAT, default 1: ALU result latency, in cycles, from the alu_en issue edge to a valid alu_c (legal range 1-15).
REQ-002 The block SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1: reset, synchronous, active-low.
REQ-004 The block SHALL have ports req0/req1, input, 1 each: operation request from requester 0/1.
REQ-005 The block SHALL have ports a0/a1 and b0/b1, input, 8 each: operands for requester 0/1.
REQ-006 The block SHALL have ports modo0/modo1, input, 2 each: operation for requester 0/1 (00 add, 01 sub, 10 mul, 11 shift-left).
REQ-007 The block SHALL have ports done0/done1, output, 1 each: one-cycle completion pulse to requester 0/1.
REQ-008 The block SHALL have ports res0/res1, output, 8 each: result for requester 0/1.
REQ-009 The block SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-010 The block SHALL have ports alu_en (output, 1), alu_a (output, 8), alu_b (output, 8) and alu_modo (output, 2): drive to the shared ALU.
REQ-011 The block SHALL have port alu_c, input, 8: shared ALU result.

Function
REQ-012 The FSM SHALL have four states: IDLE, ISSUE, WAIT and DONE.
REQ-013 In IDLE with any req high, the block SHALL grant one requester, latch its a/b/modo and owner id, and go to ISSUE the next cycle.
REQ-014 Arbitration SHALL be two-way round-robin: on simultaneous requests, grant the requester not served last; a single request wins regardless of the pointer.
REQ-015 In ISSUE, alu_en SHALL be 1 for exactly one cycle; the wait counter SHALL load LAT; the next state SHALL be WAIT.
REQ-016 alu_a, alu_b and alu_modo SHALL hold the latched values, unchanged, from ISSUE through the end of WAIT.
REQ-017 WAIT SHALL last exactly LAT cycles; on its last cycle the block SHALL capture alu_c into the owner's res register and go to DONE.
REQ-018 In DONE, the owner's done SHALL pulse high for one cycle and the last-served pointer SHALL update to the owner; the next state SHALL be IDLE.
REQ-019 res0/res1 SHALL hold their value until the next completion for the same requester; the other requester's res SHALL be unaffected.
REQ-020 A request SHALL be served in exactly LAT+3 cycles from the first IDLE cycle with req high to the done pulse, for a sustained throughput of one operation per LAT+3 cycles.
REQ-021 Handshake: reqX SHALL be held high until doneX; if reqX is still high in the cycle after doneX, it SHALL be a new request.
REQ-022 If req drops before done, the operation SHALL complete and done SHALL still pulse.
REQ-023 Operand or req changes after the grant SHALL be ignored.
REQ-024 The block SHALL perform no arithmetic: results SHALL be alu_c passed through unmodified (ALU truncation to 8 bits applies).
REQ-025 done0 and done1 SHALL never be high in the same cycle.

Reset
REQ-026 With rst low at a clk edge, the block SHALL enter IDLE, with the last-served pointer set to 1 so that req0 wins the first tie.
REQ-027 With rst low at a clk edge, the block SHALL clear the counter, owner, res0, res1, done0, done1, busy, alu_en, alu_a, alu_b and alu_modo to 0.
REQ-028 Reset asserted mid-operation (ISSUE/WAIT/DONE) SHALL abort it with no done pulse; the first grant SHALL be possible in the first cycle after rst returns high.

Structure
REQ-029 Shared package alu_pkg SHALL hold the modo encodings (MODO_ADD=00, MODO_SUB=01, MODO_MUL=10, MODO_SHL=11), the FSM state typedef, and the data width constant (8).
REQ-030 The two-way round-robin picker SHALL be one sub-module, rr_arb2, with inputs req0, req1 and last and outputs gnt0 and gnt1; it SHALL be purely combinational.

Verification
REQ-031 Single add: req0 with a0=0x0A, b0=0x05, modo0=00, LAT=1 -> done0 at cycle 4, res0=0x0F, res1 stays 0x00.
REQ-032 Tie after reset: req0 mul 0x0A*0x05 and req1 sub 0x09-0x03 asserted together -> done0 first with res0=0x32, then done1 with res1=0x06, four cycles apart.
REQ-033 Fairness: both reqs held continuously for 6 operations -> dones strictly alternate 0,1,0,1,0,1 and never overlap.
REQ-034 Shift and latency: LAT=3, req1 a1=0x09, b1=0x03, modo1=11 -> alu_en high for one cycle, operands stable 4 cycles, done1 at cycle 6, res1=0x48.
REQ-035 Reset mid-WAIT: rst low during WAIT -> no done pulse, all outputs 0 next cycle; a held req0 add 0x09+0x03 is re-served after release, giving res0=0x0C.
REQ-036 Early drop: req0 deasserted in the cycle after grant -> done0 still pulses and res0 is updated.
